// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO definitions: default widths, output buffer depth and the
// pointer-difference helper used by both read and write controllers.
package fifo_rd_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int OUT_BUF_DEPTH  = 2;

  // (a - b) mod 2**pw; pointers carry a wrap bit so pw = ADDR_WIDTH+1
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int pw);
    ptr_diff = (a - b) & ((32'd1 << pw) - 32'd1);
  endfunction
endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry head/skid register pair; strict FIFO order, flush drops contents.
module fifo_out_skid
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] head_q, skid_q;
  logic [1:0]            cnt_q;
  logic                  pop_q, take_head, skid_full;

  assign pop_q     = pop & (cnt_q != 2'd0);
  assign skid_full = (cnt_q == 2'(OUT_BUF_DEPTH));
  // new word lands in head when head is (or is becoming) free and skid is empty
  assign take_head = (cnt_q == 2'd0) | (pop_q & (cnt_q == 2'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      if (pop_q && skid_full) head_q <= skid_q;
      if (push) begin
        if (take_head) head_q <= push_data;
        else           skid_q <= push_data;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_q};
    end
  end

  assign head  = head_q;
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues RAM reads against the write pointer and
// streams the 1-cycle-latency RAM data out through a 2-entry skid buffer.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_ext,
  output logic [ADDR_WIDTH:0]   rd_ptr_ext,
  output logic [ADDR_WIDTH-1:0] rd_pointer,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] level
);
  localparam int LW = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH:0] rp;
  logic                pend, pop, ram_avail, issue;
  logic [1:0]          buf_cnt;
  logic [2:0]          occ;

  assign pop       = m_valid & m_ready;
  assign ram_avail = (wr_ptr_ext != rp);
  assign occ       = {2'b0, pend} + {1'b0, buf_cnt};
  // a pop this cycle frees a slot, so the limit is relaxed by one
  assign issue     = rst_n & ~flush & ram_avail
                   & (occ < (3'(OUT_BUF_DEPTH) + {2'b0, pop}));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rp   <= '0;
      pend <= 1'b0;
    end else if (flush) begin
      rp   <= wr_ptr_ext;
      pend <= 1'b0;
    end else begin
      rp   <= rp + {{ADDR_WIDTH{1'b0}}, issue};
      pend <= issue;
    end
  end

  fifo_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend & ~flush),
    .push_data (ram_data),
    .pop       (pop),
    .flush     (flush),
    .head      (m_data),
    .valid     (m_valid),
    .count     (buf_cnt)
  );

  assign rd_en      = issue;
  assign rd_ptr_ext = rp;
  assign rd_pointer = rp[ADDR_WIDTH-1:0];
  assign level      = LW'(ptr_diff(32'(wr_ptr_ext), 32'(rp), ADDR_WIDTH + 1))
                    + LW'(pend) + LW'(buf_cnt);
  // reported empty while held in reset regardless of the write side's pointer
  assign empty      = ~rst_n | (level == '0);
endmodule
